// File: rtl/prbs9_pkg.sv
// Shared PRBS-9 definitions for the D-PHY BIST generator/checker pair.
// The serial stream obeys b[n] = b[n-9] ^ b[n-5], and bytes are packed LSB-first.
// History layout: bit 0 holds the oldest bit b[n-9] and bit 8 holds the newest bit b[n-1].
package prbs9_pkg;

   localparam int PRBS9_TAP_A = 9;
   localparam int PRBS9_TAP_B = 5;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   typedef struct packed {
      logic [8:0] hist;
      logic [7:0] data;
   } prbs9_step_t;

   // Produces the next 8 serial bits from a 9-bit history. Each predicted bit is
   // shifted back into the history, so later bits of the same byte depend on
   // earlier bits of that byte.
   function automatic prbs9_step_t prbs9_next_byte(input logic [8:0] history);
      prbs9_step_t r;
      logic [8:0]  h;
      logic        nb;
      h      = history;
      nb     = 1'b0;
      r.data = '0;
      for (int i = 0; i < 8; i++) begin
         nb        = h[9 - PRBS9_TAP_A] ^ h[9 - PRBS9_TAP_B];
         r.data[i] = nb;
         h         = {nb, h[8:1]};
      end
      r.hist = h;
      return r;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/prbs9_checker_err_counter.sv
// Saturating bit-error accumulator. A clear overrides an increment in the same cycle.
// CNT_W must be at least 4 so that a whole byte's worth of errors fits into one step.
module prbs9_err_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             inc_en_i,
   input  logic [3:0]       inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W:0]   sum;

   // Next count: clear first, otherwise add and clamp to all-ones on carry out.
   always_comb begin
      sum     = {1'b0, count_q} + {{(CNT_W-3){1'b0}}, inc_i};
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_en_i) begin
         count_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prbs9_checker.sv
// Receive-side PRBS-9 checker. It self-synchronises on the received byte stream,
// then checks every byte against a free-running LFSR.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   HUNT   | predict from received history; count consecutive good bytes
//   LOCKED | predict from free-running lfsr; count errors, watch for loss
module prbs9_checker
   import prbs9_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 4,
   parameter int CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             RxRst,
   input  logic             Enable,
   input  logic             RxValid,
   input  logic [7:0]       RxData,
   input  logic             ClearCnt,
   output logic             Locked,
   output logic             ErrFlag,
   output logic [CNT_W-1:0] BitErrCount
);

   localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
   localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

   chk_state_e  state_q, state_d;
   logic [8:0]  hist_q, hist_d;
   logic [8:0]  lfsr_q, lfsr_d;
   logic [3:0]  good_q, good_d;
   logic [3:0]  bad_q, bad_d;
   logic        err_q, err_d;

   logic        take;
   logic [8:0]  pred_src;
   prbs9_step_t pred;
   logic [7:0]  diff;
   logic        byte_match;
   logic        hist_nz;
   logic        cnt_inc_en;

   assign take = Enable & RxValid;

   // HUNT predicts from the received history, LOCKED predicts from the lfsr.
   // Both use the same unrolled next-byte function.
   assign pred_src   = (state_q == LOCKED) ? lfsr_q : hist_q;
   assign pred       = prbs9_next_byte(pred_src);
   assign diff       = RxData ^ pred.data;
   assign byte_match = (diff == 8'h00);
   assign hist_nz    = (hist_q != 9'h000);

   // Next-state logic and byte classification. Nothing moves unless a byte is taken.
   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      lfsr_d     = lfsr_q;
      good_d     = good_q;
      bad_d      = bad_q;
      err_d      = 1'b0;
      cnt_inc_en = 1'b0;
      if (take) begin
         hist_d = {RxData, hist_q[8]};
         case (state_q)
            HUNT: begin
               // A zero history predicts zeros, so an idle all-zero stream must never lock.
               if (byte_match && hist_nz) begin
                  if (good_q == LOCK_LAST) begin
                     state_d = LOCKED;
                     good_d  = '0;
                     bad_d   = '0;
                     lfsr_d  = {RxData, hist_q[8]};
                  end else begin
                     good_d = good_q + 4'd1;
                  end
               end else begin
                  good_d = '0;
               end
            end
            LOCKED: begin
               // The lfsr advances on its own prediction, so line errors never reach it.
               lfsr_d = pred.hist;
               if (!byte_match) begin
                  err_d      = 1'b1;
                  cnt_inc_en = 1'b1;
                  if (bad_q == LOSS_LAST) begin
                     state_d = HUNT;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + 4'd1;
                  end
               end else begin
                  bad_d = '0;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (RxRst) begin
         state_q <= HUNT;
         hist_q  <= '0;
         lfsr_q  <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         lfsr_q  <= lfsr_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
      end
   end

   // Errors are only counted while LOCKED. The errored byte that causes loss of lock is still counted.
   prbs9_err_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk_i    (Clk),
      .rst_i    (RxRst),
      .clear_i  (ClearCnt & Enable),
      .inc_en_i (cnt_inc_en),
      .inc_i    (popcount8(diff)),
      .count_o  (BitErrCount)
   );

   assign Locked  = (state_q == LOCKED);
   assign ErrFlag = err_q;

endmodule

// File: tb/tb_prbs9_checker.sv
module tb_prbs9_checker;

   localparam int LOCK_N = 6;   // history fill (2 bytes) plus 4 matches

   logic        Clk = 1'b0;
   logic        RxRst;
   logic        Enable;
   logic        RxValid;
   logic [7:0]  RxData;
   logic        ClearCnt;
   logic        Locked, ErrFlag;
   logic [15:0] BitErrCount;
   logic        Locked4, ErrFlag4;
   logic [3:0]  BitErrCount4;

   int tests = 0;
   int fails = 0;
   logic [8:0] g_hist;

   prbs9_checker #(.LOCK_COUNT(4), .LOSS_COUNT(4), .CNT_W(16)) u_dut (
      .Clk(Clk), .RxRst(RxRst), .Enable(Enable), .RxValid(RxValid), .RxData(RxData),
      .ClearCnt(ClearCnt), .Locked(Locked), .ErrFlag(ErrFlag), .BitErrCount(BitErrCount));

   prbs9_checker #(.LOCK_COUNT(4), .LOSS_COUNT(4), .CNT_W(4)) u_dut4 (
      .Clk(Clk), .RxRst(RxRst), .Enable(Enable), .RxValid(RxValid), .RxData(RxData),
      .ClearCnt(ClearCnt), .Locked(Locked4), .ErrFlag(ErrFlag4), .BitErrCount(BitErrCount4));

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Serial reference generator: b[n] = b[n-9] ^ b[n-5]; g_hist[0] is the oldest bit.
   task automatic gen_byte(output logic [7:0] b);
      logic nb;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         nb     = g_hist[0] ^ g_hist[4];
         b[i]   = nb;
         g_hist = {nb, g_hist[8:1]};
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic v, input logic e, input logic clr);
      RxData   = d;
      RxValid  = v;
      Enable   = e;
      ClearCnt = clr;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      RxRst = 1'b1; Enable = 1'b0; RxValid = 1'b0; ClearCnt = 1'b0; RxData = 8'h00;
      @(posedge Clk);
      #1;
      RxRst = 1'b0;
   endtask

   initial begin
      logic [7:0] s;
      int pulses, bad, exp_cnt, kk, processed, cyc, any_lock;
      logic v, e;

      // 1: reset values, then lock on a clean stream and run it for 600 bytes
      do_reset();
      check("rst_locked", Locked, 0);
      check("rst_errflag", ErrFlag, 0);
      check("rst_count", BitErrCount, 0);
      check("rst_count4", BitErrCount4, 0);
      g_hist = 9'h1FF;
      pulses = 0;
      for (int n = 1; n <= 8; n++) begin
         gen_byte(s);
         drive(s, 1'b1, 1'b1, 1'b0);
         check("s1_lock_seq", Locked, (n >= LOCK_N) ? 1 : 0);
         if (ErrFlag) pulses++;
      end
      for (int n = 9; n <= 600; n++) begin
         gen_byte(s);
         drive(s, 1'b1, 1'b1, 1'b0);
         if (ErrFlag) pulses++;
      end
      check("s1_pulses", pulses, 0);
      check("s1_count", BitErrCount, 0);
      check("s1_locked", Locked, 1);

      // 2: a single byte with two flipped bits
      gen_byte(s);
      drive(s ^ 8'h81, 1'b1, 1'b1, 1'b0);
      check("s2_errflag", ErrFlag, 1);
      check("s2_count", BitErrCount, 2);
      check("s2_count4", BitErrCount4, 2);
      check("s2_locked", Locked, 1);
      gen_byte(s);
      drive(s, 1'b1, 1'b1, 1'b0);
      check("s2_flag_clear", ErrFlag, 0);
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         gen_byte(s);
         drive(s, 1'b1, 1'b1, 1'b0);
         if (ErrFlag) pulses++;
      end
      check("s2_no_prop", pulses, 0);
      check("s2_count_hold", BitErrCount, 2);
      check("s2_locked_hold", Locked, 1);

      // 3: zero bytes replace the stream until lock is lost, then relock
      exp_cnt = 2;
      bad = 0;
      for (int k = 0; k < 12 && bad < 4; k++) begin
         gen_byte(s);
         drive(8'h00, 1'b1, 1'b1, 1'b0);
         if (s != 8'h00) bad++; else bad = 0;
         exp_cnt += $countones(s);
         check("s3_errflag", ErrFlag, (s != 8'h00) ? 1 : 0);
         check("s3_locked", Locked, (bad < 4) ? 1 : 0);
      end
      check("s3_count", BitErrCount, exp_cnt);
      // First clean byte sees all-zero history; second matches only if the true prior bit was 0
      kk = g_hist[8] ? 6 : 5;
      for (int c = 1; c <= 8; c++) begin
         gen_byte(s);
         drive(s, 1'b1, 1'b1, 1'b0);
         check("s3_relock", Locked, (c >= kk) ? 1 : 0);
         check("s3_hunt_flag", ErrFlag, 0);
      end
      check("s3_count_hold", BitErrCount, exp_cnt);

      // 4: all-zero input never locks
      do_reset();
      any_lock = 0;
      pulses = 0;
      for (int n = 0; n < 50; n++) begin
         drive(8'h00, 1'b1, 1'b1, 1'b0);
         if (Locked) any_lock++;
         if (ErrFlag) pulses++;
      end
      check("s4_any_lock", any_lock, 0);
      check("s4_pulses", pulses, 0);
      check("s4_count", BitErrCount, 0);

      // 5: random valid/enable gaps on a clean stream
      do_reset();
      g_hist = 9'h1FF;
      processed = 0;
      cyc = 0;
      pulses = 0;
      while (processed < 100 && cyc < 2000) begin
         v = 1'($urandom_range(0, 1));
         e = 1'($urandom_range(0, 1));
         if (v && e) begin
            gen_byte(s);
            processed++;
            drive(s, 1'b1, 1'b1, 1'b0);
         end else begin
            drive(8'($urandom), v, e, 1'b0);
         end
         check("s5_lock_seq", Locked, (processed >= LOCK_N) ? 1 : 0);
         if (ErrFlag) pulses++;
         cyc++;
      end
      check("s5_processed", processed, 100);
      check("s5_pulses", pulses, 0);
      check("s5_count", BitErrCount, 0);
      gen_byte(s);
      drive(s ^ 8'hFF, 1'b1, 1'b1, 1'b0);
      check("s5_err8", BitErrCount, 8);
      gen_byte(s);
      drive(s ^ 8'h0F, 1'b1, 1'b1, 1'b1);
      check("s5_clr_prio", BitErrCount, 0);
      check("s5_clr_prio4", BitErrCount4, 0);
      check("s5_clr_flag", ErrFlag, 1);
      gen_byte(s);
      drive(s, 1'b1, 1'b1, 1'b0);
      check("s5_locked", Locked, 1);

      // 6: saturation in the 4-bit counter, enable hold, then mid-stream reset
      for (int k = 1; k <= 3; k++) begin
         gen_byte(s);
         drive(s ^ 8'hFF, 1'b1, 1'b1, 1'b0);
         check("s6_count4", BitErrCount4, (k == 1) ? 8 : 15);
         check("s6_count16", BitErrCount, 8 * k);
         gen_byte(s);
         drive(s, 1'b1, 1'b1, 1'b0);
      end
      check("s6_sat_hold", BitErrCount4, 15);
      drive(8'h5A, 1'b1, 1'b0, 1'b1);
      check("s6_en_locked", Locked, 1);
      check("s6_en_flag", ErrFlag, 0);
      check("s6_en_count", BitErrCount, 24);
      gen_byte(s);
      drive(s, 1'b1, 1'b1, 1'b0);
      check("s6_en_frozen", ErrFlag, 0);
      check("s6_en_count4", BitErrCount4, 15);
      RxRst = 1'b1; Enable = 1'b0;
      @(posedge Clk);
      #1;
      RxRst = 1'b0;
      check("s6_rst_locked", Locked, 0);
      check("s6_rst_count", BitErrCount, 0);
      check("s6_rst_count4", BitErrCount4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
